// File: rtl/arb_apb_pkg.sv
// arb_apb_pkg: register map, reset values and shared enums for the arbiter APB register block.
package arb_apb_pkg;
    localparam logic [7:0] ADDR_BYPASS = 8'h10;
    localparam logic [7:0] ADDR_REQ    = 8'h14;
    localparam logic [7:0] ADDR_GNT    = 8'h18;
    localparam logic [7:0] ADDR_TYPE   = 8'h1C;
    localparam logic       RST_BYPASS  = 1'b0;
    localparam logic [3:0] RST_REQ     = 4'b0000;
    typedef enum logic [2:0] {FIXED0, FIXED1, FIXED2, FIXED3, RR = 3'd4, WRR = 3'd5} arb_type_e;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/arb_apb_regs.sv
// arb_apb_regs: APB slave holding the arbiter BYPASS/REQ/ARB_TYPE controls and muxing software
// requests onto the arbiter when bypassed; software REQ bits self-clear on grant.
module arb_apb_regs
    import arb_apb_pkg::*;
#(
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [2:0]  RST_ARB_TYPE = 3'(RR)
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    input  logic [3:0] REQ,
    input  logic [3:0] GNT,
    output logic       APB_BYPASS,
    output logic [3:0] APB_REQ,
    output logic [2:0] APB_ARB_TYPE,
    output logic [3:0] ARB_REQ
);
    apb_state_e state_q, st;
    logic [2:0] cnt;
    logic [3:0] gnt_q;
    logic       done, err, wr;
    logic [7:0] rdata;

    // The setup phase is recognised combinationally, so ACCESS begins on the first PENABLE cycle.
    always_comb begin
        st = (state_q == ACCESS) ? ACCESS : (PSEL && !PENABLE) ? SETUP : IDLE;
        done = (st == ACCESS) && PSEL && PENABLE && (cnt == 3'(WAIT_STATES));
        err = (PADDR == ADDR_BYPASS) ? (PWRITE && PWDATA[7:1] != 7'd0) :
              (PADDR == ADDR_REQ)    ? (PWRITE && PWDATA[7:4] != 4'd0) :
              (PADDR == ADDR_GNT)    ? PWRITE :
              (PADDR == ADDR_TYPE)   ? (PWRITE && (PWDATA[7:3] != 5'd0 || PWDATA[2:1] == 2'b11)) :
              1'b1;
        rdata = (PADDR == ADDR_BYPASS) ? {7'd0, APB_BYPASS} :
                (PADDR == ADDR_REQ)    ? {4'd0, APB_REQ} :
                (PADDR == ADDR_GNT)    ? {4'd0, GNT} :
                (PADDR == ADDR_TYPE)   ? {5'd0, APB_ARB_TYPE} :
                8'd0;
        wr = done && PWRITE && !err;
        PREADY = done;
        PSLVERR = done && err;
        PRDATA = (done && !PWRITE) ? rdata : 8'd0;
        ARB_REQ = APB_BYPASS ? APB_REQ : REQ;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt <= 3'd0;
        end else if (st == SETUP) begin
            state_q <= ACCESS;
            cnt <= 3'd0;
        end else if (st == ACCESS) begin
            state_q <= (done || !(PSEL && PENABLE)) ? IDLE : ACCESS;
            cnt <= done ? 3'd0 : cnt + 3'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            APB_BYPASS <= RST_BYPASS;
            APB_REQ <= RST_REQ;
            APB_ARB_TYPE <= RST_ARB_TYPE;
            gnt_q <= 4'd0;
        end else begin
            gnt_q <= GNT;
            APB_BYPASS <= (wr && PADDR == ADDR_BYPASS) ? PWDATA[0] : APB_BYPASS;
            APB_ARB_TYPE <= (wr && PADDR == ADDR_TYPE) ? PWDATA[2:0] : APB_ARB_TYPE;
            APB_REQ <= (wr && PADDR == ADDR_REQ) ? PWDATA[3:0] :
                       APB_BYPASS ? (APB_REQ & ~(GNT & ~gnt_q)) : APB_REQ;
        end
    end
endmodule

// File: tb/tb_arb_apb_regs.sv
// tb_arb_apb_regs: directed APB transfers with a response scoreboard plus direct register-output checks.
module tb_arb_apb_regs;
    logic       PCLK = 0, PRESETn = 0;
    logic       PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [7:0] PADDR = 0, PWDATA = 0, PRDATA;
    logic       PREADY, PSLVERR;
    logic [3:0] REQ = 4'b1010, GNT = 0, APB_REQ, ARB_REQ;
    logic       APB_BYPASS;
    logic [2:0] APB_ARB_TYPE;
    int total = 0, bad = 0;
    logic [8:0] expq[$];
    logic       gd_en = 0;
    logic [3:0] gd_val = 0;

    arb_apb_regs #(.WAIT_STATES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .REQ(REQ), .GNT(GNT), .APB_BYPASS(APB_BYPASS), .APB_REQ(APB_REQ),
        .APB_ARB_TYPE(APB_ARB_TYPE), .ARB_REQ(ARB_REQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed transfer is matched against the oldest expected response.
    always @(negedge PCLK) begin
        if (PRESETn && PREADY) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pready: got 1 expected 0");
            end else begin
                logic [8:0] e;
                e = expq.pop_front();
                chk("prdata", {24'd0, PRDATA}, {24'd0, e[8:1]});
                chk("pslverr", {31'd0, PSLVERR}, {31'd0, e[0]});
            end
        end
    end

    task automatic apb(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_err);
        int n;
        expq.push_back({exp_rd, exp_err});
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1;
        for (n = 1; n <= 20; n++) begin
            @(negedge PCLK);
            if (PREADY) break;
            @(posedge PCLK); #1;
        end
        chk("access_cycles", n, 3);
        if (gd_en) GNT = gd_val;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        cyc(3);
        PRESETn = 1;
        cyc(1);
        chk("rst_bypass", APB_BYPASS, 0);
        chk("rst_req", APB_REQ, 0);
        chk("rst_type", APB_ARB_TYPE, 4);
        chk("rst_pready", PREADY, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_prdata", PRDATA, 0);
        apb(0, 8'h1C, 8'h00, 8'h04, 0);
        apb(1, 8'h14, 8'h05, 8'h00, 0);
        apb(0, 8'h14, 8'h00, 8'h05, 0);
        chk("arb_req_ext", ARB_REQ, 4'b1010);
        apb(1, 8'h10, 8'h01, 8'h00, 0);
        chk("bypass_set", APB_BYPASS, 1);
        chk("arb_req_byp", ARB_REQ, 4'b0101);
        apb(1, 8'h14, 8'h06, 8'h00, 0);
        GNT = 4'b0010;
        cyc(1);
        chk("autoclr_req", APB_REQ, 4'b0100);
        chk("autoclr_arb", ARB_REQ, 4'b0100);
        cyc(1);
        chk("autoclr_hold", APB_REQ, 4'b0100);
        GNT = 0;
        apb(1, 8'h1C, 8'h07, 8'h00, 1);
        chk("type_keep7", APB_ARB_TYPE, 4);
        apb(1, 8'h1C, 8'h06, 8'h00, 1);
        chk("type_keep6", APB_ARB_TYPE, 4);
        apb(1, 8'h1C, 8'h05, 8'h00, 0);
        chk("type_wrr", APB_ARB_TYPE, 5);
        apb(1, 8'h20, 8'h01, 8'h00, 1);
        apb(0, 8'h20, 8'h00, 8'h00, 1);
        GNT = 4'b1001;
        apb(0, 8'h18, 8'h00, 8'h09, 0);
        apb(1, 8'h18, 8'h01, 8'h00, 1);
        apb(1, 8'h10, 8'h02, 8'h00, 1);
        chk("bypass_rsvd", APB_BYPASS, 1);
        apb(1, 8'h14, 8'h13, 8'h00, 1);
        chk("req_rsvd", APB_REQ, 4'b0100);
        GNT = 0;
        cyc(2);
        gd_en = 1; gd_val = 4'b1000;
        apb(1, 8'h14, 8'h08, 8'h00, 0);
        gd_en = 0;
        chk("write_wins", APB_REQ, 4'b1000);
        cyc(2);
        chk("write_wins_hold", APB_REQ, 4'b1000);
        GNT = 0;
        cyc(1);
        GNT = 4'b1000;
        cyc(1);
        chk("autoclr_b3", APB_REQ, 4'b0000);
        GNT = 0;
        apb(1, 8'h14, 8'h0F, 8'h00, 0);
        apb(1, 8'h10, 8'h00, 8'h00, 0);
        GNT = 4'b0010;
        cyc(2);
        chk("no_autoclr", APB_REQ, 4'b1111);
        chk("arb_req_ext2", ARB_REQ, 4'b1010);
        GNT = 0;
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h10; PWDATA = 8'h01;
        @(posedge PCLK); #1;
        PENABLE = 1;
        #1;
        PRESETn = 0;
        #1;
        chk("abort_bypass", APB_BYPASS, 0);
        chk("abort_pready", PREADY, 0);
        PSEL = 0; PENABLE = 0;
        cyc(2);
        PRESETn = 1;
        cyc(2);
        chk("post_bypass", APB_BYPASS, 0);
        chk("post_pready", PREADY, 0);
        chk("post_type", APB_ARB_TYPE, 4);
        chk("post_req", APB_REQ, 0);
        apb(0, 8'h10, 8'h00, 8'h00, 0);
        cyc(3);
        chk("scoreboard_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
